instruction_fetch_unit: RTL and testbench

//  Consumer side of the program counter's address output. Captures pc_current and runs a req/ack read to

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: captures pc_current, runs a req/ack read to instruction memory and
// hands the word to decode over valid/ready. Optional alignment check: define FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int                 ADDR_W  = 64,
  parameter int                 INSTR_W = 32,
  parameter int                 TIMEOUT = 15,
  parameter logic [INSTR_W-1:0] NOP     = 32'h00000013
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_current,
  input  logic               pc_valid,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               stall,
  output logic               fetch_err,
  output logic [1:0]         state_dbg
);

  // Decode handshake: instr/instr_pc are held stable while instr_valid=1 and transfer on the
  // first cycle with instr_valid=1 and instr_ready=1; instr_valid drops the following cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 discard_q, discard_d;
  logic                 fetch_err_q, fetch_err_d;
  logic                 discard_now;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      instr_pc_q  <= '0;
      instr_q     <= NOP;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      instr_pc_q  <= instr_pc_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    instr_pc_d  = instr_pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    fetch_err_d = 1'b0;
    discard_now = discard_q | flush;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (pc_valid && !flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_current[1:0] != 2'b00) begin
            instr_pc_d  = pc_current;
            instr_d     = NOP;
            fetch_err_d = 1'b1;
            state_d     = HOLD;
          end else begin
            mem_addr_d = pc_current;
            instr_pc_d = pc_current;
            state_d    = REQ;
          end
`else
          mem_addr_d = pc_current;
          instr_pc_d = pc_current;
          state_d    = REQ;
`endif
        end
      end
      REQ: begin
        cnt_d = '0;
        if (flush) discard_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A flushed fetch still waits out its ack so the memory is never left mid-transfer.
        if (flush) discard_d = 1'b1;
        if (mem_ack) begin
          if (discard_now) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            instr_d = mem_rdata;
            state_d = HOLD;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (discard_now) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            instr_d     = NOP;
            fetch_err_d = 1'b1;
            state_d     = HOLD;
          end
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      HOLD: begin
        if (flush || instr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign stall       = (state_q != IDLE);
  assign fetch_err   = fetch_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; each scenario task checks its own expected values.
module tb_instruction_fetch_unit;

  localparam int          ADDR_W  = 64;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP_W   = 32'h00000013;

  logic               clock = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc_current;
  logic               pc_valid;
  logic               flush;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               stall;
  logic               fetch_err;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .pc_valid(pc_valid), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .stall(stall), .fetch_err(fetch_err), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clock = ~clock;

  initial begin
    reset = 1'b0; pc_current = '0; pc_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fetch(input logic [ADDR_W-1:0] pc);
    pc_current = pc;
    pc_valid   = 1'b1;
    tick();
    pc_valid   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP_W) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, NOP_W); end
    checks++; if (instr_pc !== 64'd0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got %b exp 0", fetch_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_basic_fetch();
    instr_ready = 1'b1;
    start_fetch(64'd0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", mem_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL basic_stall got %b exp 1", stall); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", instr_valid); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_one_cycle got %b exp 0", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_3rd got %b exp 1", instr_valid); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", instr); end
    checks++; if (instr_pc !== 64'd0) begin errors++; $display("FAIL basic_instr_pc got %h exp 0", instr_pc); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL basic_fetch_err got %b exp 0", fetch_err); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got %b exp 0", instr_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_idle_stall got %b exp 0", stall); end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    start_fetch(64'd4);
    checks++; if (mem_addr !== 64'd4) begin errors++; $display("FAIL bp_mem_addr got %h exp 4", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h00a00113;
    tick();
    // A stray ack with different data while holding must be ignored
    mem_rdata = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (instr !== 32'h00a00113) begin errors++; $display("FAIL bp_instr[%0d] got %h exp 00a00113", i, instr); end
      checks++; if (instr_pc !== 64'd4) begin errors++; $display("FAIL bp_instr_pc[%0d] got %h exp 4", i, instr_pc); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 1", i, stall); end
      tick();
    end
    mem_ack = 1'b0;
    instr_ready = 1'b1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b exp 1", instr_valid); end
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", instr_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", stall); end
  endtask

  task automatic test_flush_wait();
    start_fetch(64'd8);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL fw_still_wait got %0d exp 2", state_dbg); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fw_no_valid got %b exp 0", instr_valid); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL fw_idle got %0d exp 0", state_dbg); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL fw_no_err got %b exp 0", fetch_err); end
    instr_ready = 1'b1;
    start_fetch(64'd24);
    checks++; if (mem_addr !== 64'd24) begin errors++; $display("FAIL fw_next_addr got %h exp 18", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h00c00193;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr !== 32'h00c00193) begin errors++; $display("FAIL fw_next_instr got %h exp 00c00193", instr); end
    checks++; if (instr_pc !== 64'd24) begin errors++; $display("FAIL fw_next_pc got %h exp 18", instr_pc); end
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_req_and_idle();
    start_fetch(64'd28);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL fr_idle got %0d exp 0", state_dbg); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fr_no_valid got %b exp 0", instr_valid); end
    flush = 1'b1;
    start_fetch(64'd32);
    flush = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fi_no_req got %b exp 0", mem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fi_no_stall got %b exp 0", stall); end
  endtask

  task automatic test_flush_hold();
    start_fetch(64'd16);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h00208233;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fh_valid got %b exp 1", instr_valid); end
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fh_dropped got %b exp 0", instr_valid); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL fh_idle got %0d exp 0", state_dbg); end
  endtask

  task automatic test_timeout();
    start_fetch(64'd12);
    tick();
    for (int i = 2; i <= 15; i++) begin
      tick();
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL to_wait[%0d] got %0d exp 2", i, state_dbg); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_early_err[%0d] got %b exp 0", i, fetch_err); end
    end
    tick();
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", fetch_err); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL to_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== NOP_W) begin errors++; $display("FAIL to_instr got %h exp %h", instr, NOP_W); end
    checks++; if (instr_pc !== 64'd12) begin errors++; $display("FAIL to_pc got %h exp c", instr_pc); end
    tick();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", fetch_err); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL to_accept got %b exp 0", instr_valid); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    start_fetch(64'd6);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL al_no_req got %b exp 0", mem_req); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL al_err got %b exp 1", fetch_err); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL al_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== NOP_W) begin errors++; $display("FAIL al_instr got %h exp %h", instr, NOP_W); end
    checks++; if (instr_pc !== 64'd6) begin errors++; $display("FAIL al_pc got %h exp 6", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL al_pulse got %b exp 0", fetch_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL al_idle got %b exp 0", stall); end
  endtask
`else
  task automatic test_align();
    start_fetch(64'd6);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ua_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 64'd6) begin errors++; $display("FAIL ua_addr got %h exp 6", mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h00310233;
    tick();
    mem_ack = 1'b0;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL ua_err got %b exp 0", fetch_err); end
    checks++; if (instr !== 32'h00310233) begin errors++; $display("FAIL ua_instr got %h exp 00310233", instr); end
    checks++; if (instr_pc !== 64'd6) begin errors++; $display("FAIL ua_pc got %h exp 6", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_fetch();
    start_fetch(64'd40);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rm_idle got %0d exp 0", state_dbg); end
    checks++; if (instr_pc !== 64'd0) begin errors++; $display("FAIL rm_pc got %h exp 0", instr_pc); end
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ack got %b exp 0", instr_valid); end
    checks++; if (instr !== NOP_W) begin errors++; $display("FAIL rm_instr got %h exp %h", instr, NOP_W); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_req_and_idle();
    test_flush_hold();
    test_timeout();
    test_align();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
